mm_op_sequencer: RTL and testbench

- Sequences operand pairs from the UART receive path into the modular multiplier datapath and hands each product to a downstream result consumer (Tx or debug capture) through a valid/ready handshake.
- Sits between the Rx deserializer (X, Y, ready) and the multiplier core (Xin/Yin/in_valid, out_valid/Q).
- Replaces a free-running level in_valid with a one-cycle issue pulse per operand pair.
- Adds a one-deep operand buffer, sticky overflow/timeout flags and an operation counter.

---
 rtl/mm_op_sequencer.sv | 148 ++++++++++++++
 tb/tb_mm_op_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mm_op_sequencer.sv
// Operand-pair sequencer between the Rx deserializer and the modular multiplier.
// Optional multiplier-latency watchdog compiled in with `define MM_SEQ_TIMEOUT_EN.
module mm_op_sequencer #(
  parameter int W              = 256,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_ready,
  input  logic [W-1:0]     x_in,
  input  logic [W-1:0]     y_in,
  output logic [W-1:0]     mm_x,
  output logic [W-1:0]     mm_y,
  output logic             mm_in_valid,
  input  logic             mm_out_valid,
  input  logic [W-1:0]     mm_q,
  output logic [W-1:0]     res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             overflow,
  output logic             timeout,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t           state_q, state_d;
  logic             rx_ready_q;
  logic             pend_valid_q, pend_valid_d;
  logic [W-1:0]     pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [W-1:0]     mm_x_q, mm_x_d, mm_y_q, mm_y_d;
  logic             mm_in_valid_q, mm_in_valid_d;
  logic [W-1:0]     res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic rx_edge, take, result_in, handoff, to_hit;

  assign rx_edge   = rx_ready & ~rx_ready_q;
  assign take      = (state_q == IDLE) & pend_valid_q;
  assign result_in = (state_q == WAIT) & mm_out_valid;
  assign handoff   = (state_q == HOLD) & res_ready;

`ifdef MM_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;

  // A result on the terminal count takes priority over the abort.
  assign to_hit = (state_q == WAIT) & ~mm_out_valid &
                  (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q | to_hit;
    if (state_q == ISSUE)     to_cnt_d = '0;
    else if (state_q == WAIT) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  // TIMEOUT_CYCLES has no effect in this build; the flag is a constant 0.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pend_valid_q) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (mm_out_valid) state_d = HOLD;
             else if (to_hit)  state_d = IDLE;
      HOLD:  if (res_ready)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mm_in_valid_d = (state_d == ISSUE);
    res_valid_d   = (state_d == HOLD);
    mm_x_d        = take ? pend_x_q : mm_x_q;
    mm_y_d        = take ? pend_y_q : mm_y_q;
    res_data_d    = result_in ? mm_q : res_data_q;
    op_count_d    = handoff ? op_count_q + CNT_W'(1) : op_count_q;
    pend_x_d      = rx_edge ? x_in : pend_x_q;
    pend_y_d      = rx_edge ? y_in : pend_y_q;
    pend_valid_d  = rx_edge ? 1'b1 : (take ? 1'b0 : pend_valid_q);
    // Only a pair that is overwritten without having been issued is lost.
    overflow_d    = overflow_q | (rx_edge & pend_valid_q & ~take);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_ready_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_x_q      <= '0;
      pend_y_q      <= '0;
      mm_x_q        <= '0;
      mm_y_q        <= '0;
      mm_in_valid_q <= 1'b0;
      res_data_q    <= '0;
      res_valid_q   <= 1'b0;
      overflow_q    <= 1'b0;
      op_count_q    <= '0;
    end else begin
      rx_ready_q    <= rx_ready;
      pend_valid_q  <= pend_valid_d;
      pend_x_q      <= pend_x_d;
      pend_y_q      <= pend_y_d;
      mm_x_q        <= mm_x_d;
      mm_y_q        <= mm_y_d;
      mm_in_valid_q <= mm_in_valid_d;
      res_data_q    <= res_data_d;
      res_valid_q   <= res_valid_d;
      overflow_q    <= overflow_d;
      op_count_q    <= op_count_d;
    end
  end

  assign mm_x        = mm_x_q;
  assign mm_y        = mm_y_q;
  assign mm_in_valid = mm_in_valid_q;
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign overflow    = overflow_q;
  assign op_count    = op_count_q;
  assign busy        = (state_q != IDLE) | pend_valid_q;

endmodule

// File: tb/tb_mm_op_sequencer.sv
// Directed bench for mm_op_sequencer: vector table of single operations plus
// hand-written queued, overflow, reset-abort and timeout sequences.
module tb_mm_op_sequencer;
  localparam int W     = 256;
  localparam int CNT_W = 16;
  localparam int TO    = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             rx_ready = 1'b0;
  logic [W-1:0]     x_in = '0, y_in = '0, mm_q = '0;
  logic             mm_out_valid = 1'b0;
  logic             res_ready = 1'b1;
  logic [W-1:0]     mm_x, mm_y, res_data;
  logic             mm_in_valid, res_valid, busy, overflow, timeout;
  logic [CNT_W-1:0] op_count;

  mm_op_sequencer #(.W(W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .rx_ready(rx_ready), .x_in(x_in), .y_in(y_in),
    .mm_x(mm_x), .mm_y(mm_y), .mm_in_valid(mm_in_valid), .mm_out_valid(mm_out_valid),
    .mm_q(mm_q), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .overflow(overflow), .timeout(timeout), .op_count(op_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int nchk = 0, nfail = 0, exp_cnt = 0;

  // Multiplier model: returns X*Y mdl_lat cycles after the issue pulse.
  bit       mdl_en = 1'b1;
  int       mdl_lat = 4;
  int       mdl_cnt = 0;
  logic [W-1:0] qa, qb;
  initial forever begin
    @(negedge clock);
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin mm_out_valid = 1'b1; mm_q = qa * qb; end
    end else mm_out_valid = 1'b0;
    if (mm_in_valid && mdl_en) begin mdl_cnt = mdl_lat; qa = mm_x; qb = mm_y; end
  end

  initial begin #100000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %0d, required %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_for(input int sel, input string nm);
    int n = 0;
    while (!((sel == 0) ? mm_in_valid : res_valid) && n < 60) begin @(negedge clock); n++; end
    if (!((sel == 0) ? mm_in_valid : res_valid)) begin
      nchk++; nfail++;
      $display("FAIL %s: got no response in 60 cycles, required 1", nm);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_mm_x"}, mm_x, 0);         chk({nm, "_mm_y"}, mm_y, 0);
    chk({nm, "_res_data"}, res_data, 0); chk({nm, "_in_valid"}, mm_in_valid, 0);
    chk({nm, "_res_valid"}, res_valid, 0); chk({nm, "_busy"}, busy, 0);
    chk({nm, "_overflow"}, overflow, 0); chk({nm, "_timeout"}, timeout, 0);
    chk({nm, "_op_count"}, op_count, 0);
  endtask

  task automatic run_op(input logic [W-1:0] x, y, q, input int lat, rrd);
    int t0, ti, th;
    mdl_lat = lat; res_ready = (rrd == 0);
    x_in = x; y_in = y; rx_ready = 1'b1; t0 = cyc;
    @(negedge clock); wait_for(0, "issue");
    ti = cyc;
    chk("issue_lat", ti - t0, 2); chk("mm_x", mm_x, x); chk("mm_y", mm_y, y);
    @(negedge clock); rx_ready = 1'b0;
    chk("in_valid_pulse", mm_in_valid, 0); chk("busy_wait", busy, 1);
    wait_for(1, "res_valid");
    th = cyc;
    chk("res_lat", th - ti, lat + 1); chk("res_data", res_data, q);
    for (int k = 0; k < rrd; k++) begin
      @(negedge clock);
      chk("hold_valid", res_valid, 1); chk("hold_data", res_data, q);
      chk("hold_cnt", op_count, exp_cnt);
      if (k == rrd - 1) res_ready = 1'b1;
    end
    @(negedge clock); exp_cnt++;
    chk("handoff_valid", res_valid, 0); chk("op_count", op_count, exp_cnt);
    chk("busy_done", busy, 0);
  endtask

  typedef struct {
    logic [W-1:0] x, y, q;
    int           lat, rrd;
  } vec_t;

  vec_t tbl[5];
  int   ti, th;

  initial begin
    tbl[0] = '{x: 3,  y: 5,  q: 15,  lat: 4, rrd: 0};   // single op
    tbl[1] = '{x: 3,  y: 5,  q: 15,  lat: 4, rrd: 20};  // backpressure
    tbl[2] = '{x: 12, y: 11, q: 132, lat: 1, rrd: 3};   // shortest latency
    tbl[3] = '{x: 6,  y: 7,  q: 42,  lat: 8, rrd: 0};   // result on terminal count
    tbl[4] = '{x: (256'd1 << 200), y: (256'd1 << 10), q: (256'd1 << 210), lat: 2, rrd: 1};

    repeat (3) @(negedge clock);
    chk_zero("rst");
    reset = 1'b0;
    @(negedge clock);
    chk_zero("post_rst");

    foreach (tbl[i]) run_op(tbl[i].x, tbl[i].y, tbl[i].q, tbl[i].lat, tbl[i].rrd);
    chk("no_ovf_singles", overflow, 0);

    // Queued pair arriving during WAIT of the first
    mdl_lat = 4; res_ready = 1'b1;
    x_in = 3; y_in = 5; rx_ready = 1'b1;
    @(negedge clock); wait_for(0, "q_issue1");
    chk("q_mm_x1", mm_x, 3);
    @(negedge clock); rx_ready = 1'b0;
    @(negedge clock); x_in = 7; y_in = 9; rx_ready = 1'b1;
    @(negedge clock); rx_ready = 1'b0; chk("q_busy", busy, 1);
    wait_for(1, "q_res1");
    chk("q_res1", res_data, 15); th = cyc;
    @(negedge clock); exp_cnt++;
    wait_for(0, "q_issue2");
    chk("q_issue_gap", cyc - th, 2); chk("q_mm_x2", mm_x, 7); chk("q_mm_y2", mm_y, 9);
    wait_for(1, "q_res2");
    chk("q_res2", res_data, 63);
    @(negedge clock); exp_cnt++;
    chk("q_cnt", op_count, exp_cnt); chk("q_busy_done", busy, 0); chk("q_ovf", overflow, 0);

    // Overflow: second and third pairs during first WAIT, second is lost
    mdl_lat = 6;
    x_in = 1; y_in = 1; rx_ready = 1'b1;
    @(negedge clock); wait_for(0, "o_issue1");
    @(negedge clock); rx_ready = 1'b0;
    @(negedge clock); x_in = 2; y_in = 2; rx_ready = 1'b1;
    @(negedge clock); rx_ready = 1'b0; chk("o_ovf_early", overflow, 0);
    @(negedge clock); x_in = 4; y_in = 4; rx_ready = 1'b1;
    @(negedge clock); rx_ready = 1'b0; chk("o_ovf", overflow, 1);
    wait_for(1, "o_res1");
    chk("o_res1", res_data, 1);
    @(negedge clock); exp_cnt++;
    wait_for(0, "o_issue2");
    chk("o_mm_x2", mm_x, 4);
    wait_for(1, "o_res2");
    chk("o_res2", res_data, 16);
    @(negedge clock); exp_cnt++;
    chk("o_cnt", op_count, exp_cnt); chk("o_busy", busy, 0);
    for (int k = 0; k < 5; k++) begin @(negedge clock); chk("o_no_reissue", mm_in_valid, 0); end
    chk("o_ovf_sticky", overflow, 1);

    // Reset mid-WAIT; the model's late result must be ignored
    mdl_lat = 10;
    x_in = 3; y_in = 5; rx_ready = 1'b1;
    @(negedge clock); wait_for(0, "r_issue");
    @(negedge clock); rx_ready = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0; exp_cnt = 0;
    chk_zero("r_mid");
    for (int k = 0; k < 12; k++) begin
      @(negedge clock); chk("r_no_res", res_valid, 0); chk("r_idle", busy, 0);
    end
    chk("r_cnt", op_count, 0);

    // Timeout: multiplier never responds
    mdl_en = 1'b0; res_ready = 1'b1;
    x_in = 9; y_in = 9; rx_ready = 1'b1;
    @(negedge clock); wait_for(0, "t_issue");
    ti = cyc;
    @(negedge clock); rx_ready = 1'b0;
    while (cyc < ti + 8) @(negedge clock);
    chk("t_not_yet", timeout, 0);
    @(negedge clock);
`ifdef MM_SEQ_TIMEOUT_EN
    chk("t_flag", timeout, 1); chk("t_idle", busy, 0);
    chk("t_res_valid", res_valid, 0); chk("t_cnt", op_count, exp_cnt);
    mdl_en = 1'b1;
    run_op(2, 3, 6, 4, 0);
    chk("t_sticky", timeout, 1);
`else
    chk("t_flag_off", timeout, 0); chk("t_busy", busy, 1);
    repeat (20) @(negedge clock);
    chk("t_busy_late", busy, 1); chk("t_flag_late", timeout, 0);
    chk("t_res_valid", res_valid, 0);
    mdl_en = 1'b1;
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk_zero("t_rst");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
